// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_ctrl_if : ID-stage hazard inputs and pipeline control outputs.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface hazard_ctrl_if #(
  parameter int MC_W = 4
);
  logic            id_valid;
  logic [5:0]      id_rs1_addr;
  logic [5:0]      id_rs2_addr;
  logic            id_rs1_used;
  logic            id_rs2_used;
  logic [5:0]      id_rd_addr;
  logic            id_rd_we;
  logic            id_is_load;
  logic            id_is_mc;
  logic [MC_W-1:0] id_mc_cycles;
  logic            branch_taken;
  logic            mem_stall;

  logic            pc_we;
  logic            if_id_we;
  logic            id_ex_we;
  logic            ex_mem_we;
  logic            mem_wb_we;
  logic            if_id_flush;
  logic            id_ex_flush;
  logic            ex_mem_flush;
  logic [1:0]      fwd1_sel;
  logic [1:0]      fwd2_sel;
  logic            mc_busy;

  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           id_rd_addr, id_rd_we, id_is_load, id_is_mc, id_mc_cycles,
           branch_taken, mem_stall,
    input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
           if_id_flush, id_ex_flush, ex_mem_flush, fwd1_sel, fwd2_sel, mc_busy
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           id_rd_addr, id_rd_we, id_is_load, id_is_mc, id_mc_cycles,
           branch_taken, mem_stall,
    output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
           if_id_flush, id_ex_flush, ex_mem_flush, fwd1_sel, fwd2_sel, mc_busy
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_ctrl : stall/flush/forwarding control with multi-cycle EX FSM.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module hazard_ctrl #(
  parameter int MC_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  typedef struct packed {
    logic       valid;
    logic [5:0] rd;
    logic       we;
    logic       is_load;
  } slot_t;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam logic [1:0] c_fwd_rf  = 2'b00;
  localparam logic [1:0] c_fwd_ex  = 2'b01;
  localparam logic [1:0] c_fwd_mem = 2'b10;
  localparam logic [1:0] c_fwd_wb  = 2'b11;

  slot_t           ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  state_t          state_q, state_d;
  logic [MC_W-1:0] cnt_q, cnt_d;

  logic w_busy, w_load_use, w_mc_start;
  logic w_pc_we, w_if_id_we, w_id_ex_we, w_ex_mem_we, w_mem_wb_we;
  logic w_if_id_flush, w_id_ex_flush, w_ex_mem_flush;

  function automatic logic slot_hit(input slot_t s, input logic [5:0] addr);
    return s.valid && s.we && (s.rd != 6'd0) && (s.rd == addr);
  endfunction

  // An EX load has no result yet, and a busy mc op is not final: both defer to older slots.
  function automatic logic [1:0] fwd_sel(input logic used, input logic [5:0] addr,
                                         input slot_t ex, input slot_t mem,
                                         input slot_t wb, input logic busy);
    logic [1:0] sel;
    sel = c_fwd_rf;
    if (used && (addr != 6'd0)) begin
      if (slot_hit(ex, addr) && !ex.is_load && !busy) sel = c_fwd_ex;
      else if (slot_hit(mem, addr))                   sel = c_fwd_mem;
      else if (slot_hit(wb, addr))                    sel = c_fwd_wb;
    end
    return sel;
  endfunction

  assign w_busy     = (state_q == S_BUSY);
  assign w_load_use = bus.id_valid && ex_q.is_load &&
                      ((bus.id_rs1_used && slot_hit(ex_q, bus.id_rs1_addr)) ||
                       (bus.id_rs2_used && slot_hit(ex_q, bus.id_rs2_addr)));

  always_comb begin
    w_pc_we        = 1'b1;
    w_if_id_we     = 1'b1;
    w_id_ex_we     = 1'b1;
    w_ex_mem_we    = 1'b1;
    w_mem_wb_we    = 1'b1;
    w_if_id_flush  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_ex_mem_flush = 1'b0;
    if (bus.mem_stall) begin
      w_pc_we     = 1'b0;
      w_if_id_we  = 1'b0;
      w_id_ex_we  = 1'b0;
      w_ex_mem_we = 1'b0;
      w_mem_wb_we = 1'b0;
    end else if (w_busy) begin
      w_pc_we        = 1'b0;
      w_if_id_we     = 1'b0;
      w_id_ex_we     = 1'b0;
      w_ex_mem_flush = 1'b1;
    end else if (bus.branch_taken) begin
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
    end else if (w_load_use) begin
      w_pc_we       = 1'b0;
      w_if_id_we    = 1'b0;
      w_id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (w_mem_wb_we) wb_d  = mem_q;
    if (w_ex_mem_we) mem_d = w_ex_mem_flush ? '0 : ex_q;
    if (w_id_ex_we) begin
      ex_d = '0;
      if (bus.id_valid && !w_id_ex_flush) begin
        ex_d.valid   = 1'b1;
        ex_d.rd      = bus.id_rd_addr;
        ex_d.we      = bus.id_rd_we;
        ex_d.is_load = bus.id_is_load;
      end
    end
  end

  assign w_mc_start = w_id_ex_we && !w_id_ex_flush && bus.id_valid && bus.id_is_mc;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (w_mc_start) begin
          state_d = S_BUSY;
          cnt_d   = bus.id_mc_cycles - MC_W'(1);
        end
      end
      S_BUSY: begin
        if (!bus.mem_stall) begin
          cnt_d = cnt_q - MC_W'(1);
          if (cnt_q == MC_W'(1)) state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc_we        = w_pc_we;
  assign bus.if_id_we     = w_if_id_we;
  assign bus.id_ex_we     = w_id_ex_we;
  assign bus.ex_mem_we    = w_ex_mem_we;
  assign bus.mem_wb_we    = w_mem_wb_we;
  assign bus.if_id_flush  = w_if_id_flush;
  assign bus.id_ex_flush  = w_id_ex_flush;
  assign bus.ex_mem_flush = w_ex_mem_flush;
  assign bus.fwd1_sel     = fwd_sel(bus.id_rs1_used, bus.id_rs1_addr, ex_q, mem_q, wb_q, w_busy);
  assign bus.fwd2_sel     = fwd_sel(bus.id_rs2_used, bus.id_rs2_addr, ex_q, mem_q, wb_q, w_busy);
  assign bus.mc_busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hazard_ctrl : directed table, corner sequences and random model check.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_hazard_ctrl;
  localparam int          MC_W   = 4;
  // {pc,if_id,id_ex,ex_mem,mem_wb we}{if_id,id_ex,ex_mem flush}{fwd1}{fwd2}{busy}
  localparam logic [12:0] c_idle = 13'b11111_000_00_00_0;

  typedef struct {
    logic            v;
    logic [5:0]      rs1;
    logic            u1;
    logic [5:0]      rs2;
    logic            u2;
    logic [5:0]      rd;
    logic            we;
    logic            ld;
    logic            mc;
    logic [MC_W-1:0] n;
    logic            br;
    logic            ms;
    logic [12:0]     exp;
  } vec_t;

  typedef struct {
    logic       v;
    logic [5:0] rd;
    logic       we;
    logic       ld;
  } ins_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.MC_W(MC_W)) bus ();
  hazard_ctrl #(.MC_W(MC_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int    n_vec = 0;
  int    n_err = 0;
  vec_t  tbl[$];
  string tnm[$];

  // Reference: in-flight instructions indexed by age (0 = EX, 1 = MEM, 2 = WB)
  ins_t pipe[3];
  int   busy_left;

  function automatic vec_t mk(input int v, input int rs1, input int u1, input int rs2,
                              input int u2, input int rd, input int we, input int ld,
                              input int mc, input int n, input int br, input int ms,
                              input logic [12:0] exp);
    vec_t x;
    x.v = (v != 0);   x.rs1 = 6'(rs1); x.u1 = (u1 != 0);
    x.rs2 = 6'(rs2);  x.u2 = (u2 != 0);  x.rd = 6'(rd);
    x.we = (we != 0); x.ld = (ld != 0);  x.mc = (mc != 0);
    x.n = MC_W'(n);   x.br = (br != 0);  x.ms = (ms != 0);
    x.exp = exp;
    return x;
  endfunction

  task automatic add(input string nm, input vec_t x);
    tbl.push_back(x);
    tnm.push_back(nm);
  endtask

  task automatic drive(input vec_t x);
    bus.id_valid     = x.v;
    bus.id_rs1_addr  = x.rs1;
    bus.id_rs1_used  = x.u1;
    bus.id_rs2_addr  = x.rs2;
    bus.id_rs2_used  = x.u2;
    bus.id_rd_addr   = x.rd;
    bus.id_rd_we     = x.we;
    bus.id_is_load   = x.ld;
    bus.id_is_mc     = x.mc;
    bus.id_mc_cycles = x.n;
    bus.branch_taken = x.br;
    bus.mem_stall    = x.ms;
  endtask

  task automatic check(input string nm, input logic [12:0] exp);
    logic [12:0] act;
    act = {bus.pc_we, bus.if_id_we, bus.id_ex_we, bus.ex_mem_we, bus.mem_wb_we,
           bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush,
           bus.fwd1_sel, bus.fwd2_sel, bus.mc_busy};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (we5_fl3_f1_f2_busy)", nm, act, exp);
    end
  endtask

  task automatic apply(input string nm, input vec_t x);
    @(posedge clk);
    #1;
    drive(x);
    @(negedge clk);
    check(nm, x.exp);
  endtask

  function automatic logic src(input ins_t p);
    return p.v && p.we && (p.rd != 6'd0);
  endfunction

  function automatic logic model_lu(input vec_t x);
    return x.v && src(pipe[0]) && pipe[0].ld &&
           ((x.u1 && (x.rs1 == pipe[0].rd)) || (x.u2 && (x.rs2 == pipe[0].rd)));
  endfunction

  function automatic logic [1:0] msel(input logic u, input logic [5:0] a, input logic busy);
    if (!u || (a == 6'd0)) return 2'd0;
    for (int s = 0; s < 3; s++) begin
      if (src(pipe[s]) && (pipe[s].rd == a) && !((s == 0) && (pipe[0].ld || busy)))
        return 2'(s + 1);
    end
    return 2'd0;
  endfunction

  function automatic logic [12:0] model_exp(input vec_t x);
    logic [4:0] en;
    logic [2:0] fl;
    logic       busy;
    busy = (busy_left > 0);
    if (x.ms)               begin en = 5'b00000; fl = 3'b000; end
    else if (busy)          begin en = 5'b00011; fl = 3'b001; end
    else if (x.br)          begin en = 5'b11111; fl = 3'b110; end
    else if (model_lu(x))   begin en = 5'b00111; fl = 3'b010; end
    else                    begin en = 5'b11111; fl = 3'b000; end
    return {en, fl, msel(x.u1, x.rs1, busy), msel(x.u2, x.rs2, busy), busy};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 3; s++) pipe[s] = '{1'b0, 6'd0, 1'b0, 1'b0};
    busy_left = 0;
  endtask

  task automatic model_step(input vec_t x);
    logic adv;
    if (x.ms) return;
    if (busy_left > 0) begin
      pipe[2] = pipe[1];
      pipe[1] = '{1'b0, 6'd0, 1'b0, 1'b0};
      busy_left--;
      return;
    end
    adv = x.v && !x.br && !model_lu(x);
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = adv ? '{1'b1, x.rd, x.we, x.ld} : '{1'b0, 6'd0, 1'b0, 1'b0};
    if (adv && x.mc) busy_left = int'(x.n) - 1;
  endtask

  function automatic logic [5:0] raddr();
    case ($urandom_range(0, 5))
      0:       return 6'd0;
      1:       return 6'd1;
      2:       return 6'd2;
      3:       return 6'd3;
      4:       return 6'd32;
      default: return 6'd33;
    endcase
  endfunction

  function automatic vec_t rand_vec();
    vec_t x;
    x.v   = ($urandom_range(0, 9) != 0);
    x.rs1 = raddr();
    x.u1  = ($urandom_range(0, 3) != 0);
    x.rs2 = raddr();
    x.u2  = ($urandom_range(0, 3) != 0);
    x.rd  = raddr();
    x.we  = ($urandom_range(0, 4) != 0);
    x.ld  = ($urandom_range(0, 3) == 0);
    x.mc  = !x.ld && ($urandom_range(0, 7) == 0);
    x.n   = MC_W'($urandom_range(2, 6));
    x.br  = ($urandom_range(0, 9) == 0);
    x.ms  = ($urandom_range(0, 6) == 0);
    x.exp = '0;
    return x;
  endfunction

  // Asynchronous reset asserted mid-cycle; outputs must be back to idle at once.
  task automatic do_reset(input string nm, input vec_t x);
    @(posedge clk);
    #1;
    x.br = 1'b0;
    x.ms = 1'b0;
    drive(x);
    #2;
    rst = 1'b1;
    #1;
    check(nm, c_idle);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.id_valid = 1'b0;
    bus.id_is_mc = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    add("alu_prod",      mk(1,  1,1,  2,1,  5,1,0,0,0,0,0, 13'b11111_000_00_00_0));
    add("alu_fwd_ex",    mk(1,  5,1,  1,1,  6,1,0,0,0,0,0, 13'b11111_000_01_00_0));
    add("alu_fwd_mem",   mk(1,  5,1,  6,1, 10,1,0,0,0,0,0, 13'b11111_000_10_01_0));
    add("alu_fwd_wb",    mk(1,  5,1,  0,1, 11,1,0,0,0,0,0, 13'b11111_000_11_00_0));
    add("lw_issue",      mk(1,  2,1,  0,0,  7,1,1,0,0,0,0, 13'b11111_000_00_00_0));
    add("load_use",      mk(1,  7,1,  7,1,  8,1,0,0,0,0,0, 13'b00111_010_00_00_0));
    add("load_use_fwd",  mk(1,  7,1,  7,1,  8,1,0,0,0,0,0, 13'b11111_000_10_10_0));
    add("wr_x0",         mk(1,  3,1,  4,1,  0,1,0,0,0,0,0, 13'b11111_000_00_00_0));
    add("rd_x0",         mk(1,  0,1,  0,1,  9,1,0,0,0,0,0, 13'b11111_000_00_00_0));
    add("fadd_f0",       mk(1, 33,1, 34,1, 32,1,0,0,0,0,0, 13'b11111_000_00_00_0));
    add("rd_f0",         mk(1, 32,1,  8,1, 35,1,0,0,0,0,0, 13'b11111_000_01_00_0));
    add("mc5_issue",     mk(1,  9,1,  0,0, 12,1,0,1,5,0,0, 13'b11111_000_11_00_0));
    add("mc5_busy1",     mk(1, 12,1, 32,1, 13,1,0,0,0,0,0, 13'b00011_001_00_11_1));
    add("mc5_busy2",     mk(1, 12,1, 32,1, 13,1,0,0,0,0,0, 13'b00011_001_00_00_1));
    add("mc5_busy3",     mk(1, 12,1, 32,1, 13,1,0,0,0,0,0, 13'b00011_001_00_00_1));
    add("mc5_busy4",     mk(1, 12,1, 32,1, 13,1,0,0,0,0,0, 13'b00011_001_00_00_1));
    add("mc5_final_fwd", mk(1, 12,1, 32,1, 13,1,0,0,0,0,0, 13'b11111_000_01_00_0));
    add("branch_flush",  mk(1,  1,1,  0,0, 14,1,1,0,0,1,0, 13'b11111_110_00_00_0));
    add("post_branch",   mk(1, 14,1, 13,1, 15,1,0,0,0,0,0, 13'b11111_000_00_10_0));
    add("mc4_issue",     mk(1,  0,0,  0,0, 16,1,0,1,4,0,0, 13'b11111_000_00_00_0));
    add("mc4_busy1",     mk(1, 16,1, 15,1, 17,1,0,0,0,0,0, 13'b00011_001_00_10_1));
    add("stall_hold1",   mk(1, 16,1, 15,1, 17,1,0,0,0,0,1, 13'b00000_000_00_11_1));
    add("stall_hold2",   mk(1, 16,1, 15,1, 17,1,0,0,0,0,1, 13'b00000_000_00_11_1));
    add("stall_hold3",   mk(1, 16,1, 15,1, 17,1,0,0,0,0,1, 13'b00000_000_00_11_1));
    add("mc4_busy2",     mk(1, 16,1, 15,1, 17,1,0,0,0,0,0, 13'b00011_001_00_11_1));
    add("mc4_busy3",     mk(1, 16,1, 15,1, 17,1,0,0,0,0,0, 13'b00011_001_00_00_1));
    add("mc4_final",     mk(1, 16,1, 15,1, 17,1,0,0,0,0,0, 13'b11111_000_01_00_0));

    drive(mk(0, 0,0, 0,0, 0,0,0,0,2,0,0, c_idle));
    model_reset();
    #12;
    check("reset_state", c_idle);
    #1;
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply(tnm[i], tbl[i]);

    // Reset while an mc op is counting down
    apply("mc6_issue",      mk(1,  0,0,  0,0, 20,1,0,1,6,0,0, 13'b11111_000_00_00_0));
    apply("mc6_busy",       mk(1, 20,1, 17,1, 21,1,0,0,0,0,0, 13'b00011_001_00_10_1));
    do_reset("rst_mid_busy", mk(1, 20,1, 17,1, 21,1,0,0,0,0,0, c_idle));
    apply("post_rst",       mk(1, 20,1, 17,1, 21,1,0,0,0,0,0, c_idle));

    // Branch outranks a load-use in EX; the squashed slot never forwards
    apply("lw_b",           mk(1,  1,1,  0,0,  7,1,1,0,0,0,0, 13'b11111_000_00_00_0));
    apply("br_over_lu",     mk(1,  7,1,  0,0,  8,1,0,0,0,1,0, 13'b11111_110_00_00_0));
    apply("br_after",       mk(1,  7,1,  0,0,  9,1,0,0,0,0,0, 13'b11111_000_10_00_0));

    // mem_stall on a load-use cycle must not add or drop the bubble
    apply("lw_s",           mk(1,  0,0,  0,0,  3,1,1,0,0,0,0, 13'b11111_000_00_00_0));
    apply("lu_memstall",    mk(1,  3,1,  9,1,  4,1,0,0,0,0,1, 13'b00000_000_00_10_0));
    apply("lu_after_stall", mk(1,  3,1,  9,1,  4,1,0,0,0,0,0, 13'b00111_010_00_10_0));
    apply("lu_one_bubble",  mk(1,  3,1,  9,1,  4,1,0,0,0,0,0, 13'b11111_000_10_11_0));

    do_reset("rst_rand_start", rand_vec());
    for (int k = 0; k < 3000; k++) begin
      vec_t x;
      if ($urandom_range(0, 199) == 0) begin
        do_reset("rst_rand", rand_vec());
      end else begin
        x = rand_vec();
        @(posedge clk);
        #1;
        drive(x);
        @(negedge clk);
        check($sformatf("rand_%0d", k), model_exp(x));
        model_step(x);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
